// File: rtl/psx_poll_master_if.sv
// Pad-side bus of the PSX controller poller: attention, serial clock/command out, data/ack in.
interface psx_poll_master_if;
  logic att;
  logic psx_clk;
  logic cmd;
  logic data;
  logic ack;

  modport master (output att, psx_clk, cmd, input data, ack);
  modport slave  (input att, psx_clk, cmd, output data, ack);
endinterface

// File: rtl/psx_poll_master.sv
// Polls a PSX pad: 5-byte exchange (01 42 00 00 00), ack handshake after bytes 0-3,
// validates the ID bytes and publishes the two button bytes.
module psx_poll_master #(
  parameter int HALF_PERIOD = 25,
  parameter int ATT_SETUP   = 50,
  parameter int ACK_TIMEOUT = 500,
  parameter int ACK_HOLDOFF = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [15:0]              buttons,
  output logic                     valid,
  output logic [1:0]               err,
  output logic                     busy,
  psx_poll_master_if.master        pad
);

  localparam int MAX_AB = (HALF_PERIOD > ATT_SETUP) ? HALF_PERIOD : ATT_SETUP;
  localparam int MAX_CD = (ACK_TIMEOUT > ACK_HOLDOFF) ? ACK_TIMEOUT : ACK_HOLDOFF;
  localparam int MAXC   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HP_L = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] SU_L = CW'(ATT_SETUP - 1);
  localparam logic [CW-1:0] TO_L = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] HO_L = CW'(ACK_HOLDOFF - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, CLK_LO, CLK_HI, ACK_WAIT, ACK_REL, HOLDOFF, FINISH
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_n, byte_idx, byte_n;
  logic [7:0]      rx_sr, rx_n, rx3, rx3_n, rx_bit;
  logic [15:0]     buttons_n;
  logic [1:0]      err_n;
  logic            valid_n, cmd_q, cmd_n, att_q, sclk_q, busy_q;
  logic            data_s1, data_s, ack_s1, ack_s;

  function automatic logic tx_bit(input logic [2:0] by, input logic [2:0] bi);
    logic [7:0] b;
    case (by)
      3'd0:    b = 8'h01;
      3'd1:    b = 8'h42;
      default: b = 8'h00;
    endcase
    return b[bi];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      rx_sr    <= '0;
      rx3      <= '0;
      buttons  <= 16'hFFFF;
      err      <= 2'b00;
      valid    <= 1'b0;
      cmd_q    <= 1'b1;
      att_q    <= 1'b1;
      sclk_q   <= 1'b1;
      busy_q   <= 1'b0;
      data_s1  <= 1'b1;
      data_s   <= 1'b1;
      ack_s1   <= 1'b1;
      ack_s    <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      rx_sr    <= rx_n;
      rx3      <= rx3_n;
      buttons  <= buttons_n;
      err      <= err_n;
      valid    <= valid_n;
      cmd_q    <= cmd_n;
      // Pad outputs are registered from the next state so they change glitch-free with it.
      att_q    <= (state_n == IDLE) || (state_n == FINISH);
      sclk_q   <= (state_n != CLK_LO);
      busy_q   <= (state_n != IDLE);
      data_s1  <= pad.data;
      data_s   <= data_s1;
      ack_s1   <= pad.ack;
      ack_s    <= ack_s1;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_n     = bit_idx;
    byte_n    = byte_idx;
    rx_n      = rx_sr;
    rx3_n     = rx3;
    buttons_n = buttons;
    err_n     = err;
    valid_n   = 1'b0;
    cmd_n     = cmd_q;
    rx_bit    = rx_sr;
    rx_bit[bit_idx] = data_s;

    case (state)
      IDLE: begin
        cnt_n = '0;
        cmd_n = 1'b1;
        if (start) begin
          state_n = SETUP;
          err_n   = 2'b00;
        end
      end
      SETUP: if (cnt == SU_L) begin
        state_n = CLK_LO;
        cnt_n   = '0;
        bit_n   = '0;
        byte_n  = '0;
        cmd_n   = tx_bit(3'd0, 3'd0);
      end
      CLK_LO: if (cnt == HP_L) begin
        state_n = CLK_HI;
        cnt_n   = '0;
      end
      CLK_HI: if (cnt == HP_L) begin
        cnt_n = '0;
        rx_n  = rx_bit;
        if (bit_idx == 3'd7) begin
          cmd_n = 1'b1;
          // An ack timeout already ends the transaction, so only a clean code is overwritten.
          if (((byte_idx == 3'd1) && (rx_bit != 8'h41)) ||
              ((byte_idx == 3'd2) && (rx_bit != 8'h5A)))
            if (err == 2'b00) err_n = 2'b10;
          if (byte_idx == 3'd3) rx3_n = rx_bit;
          if (byte_idx == 3'd4) begin
            state_n = FINISH;
            if (err_n == 2'b00) begin
              buttons_n = {rx_bit, rx3};
              valid_n   = 1'b1;
            end
          end else begin
            state_n = ACK_WAIT;
          end
        end else begin
          state_n = CLK_LO;
          bit_n   = 3'(bit_idx + 3'd1);
          cmd_n   = tx_bit(byte_idx, 3'(bit_idx + 3'd1));
        end
      end
      ACK_WAIT: begin
        if (!ack_s) begin
          state_n = ACK_REL;
          cnt_n   = '0;
        end else if (cnt == TO_L) begin
          state_n = FINISH;
          cnt_n   = '0;
          err_n   = 2'b01;
        end
      end
      ACK_REL: begin
        cnt_n = '0;
        if (ack_s) state_n = HOLDOFF;
      end
      HOLDOFF: if (cnt == HO_L) begin
        state_n = CLK_LO;
        cnt_n   = '0;
        bit_n   = '0;
        byte_n  = 3'(byte_idx + 3'd1);
        cmd_n   = tx_bit(3'(byte_idx + 3'd1), 3'd0);
      end
      FINISH: begin
        state_n = IDLE;
        cnt_n   = '0;
        cmd_n   = 1'b1;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign pad.att     = att_q;
  assign pad.psx_clk = sclk_q;
  assign pad.cmd     = cmd_q;
  assign busy        = busy_q;

endmodule
